// File: rtl/norm_x32.sv
// norm_x32: iterative left-normalizer for a 32-bit operand.
// A captured operand is shifted left in five binary-search steps (16, 8, 4,
// 2, 1) until bit 31 is set, accumulating the shift count as the
// leading-zero count. Latency is fixed at five STEP cycles regardless of data.
module norm_x32 (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [31:0] X,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Y,
  output logic [4:0]  Sa,
  output logic        IsZero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Index of the last normalization step (amount 1).
  localparam logic [2:0] LAST_STEP = 3'd4;

  state_t      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] y_q, y_d;
  logic [4:0]  sa_q, sa_d;
  logic        iszero_q, iszero_d;

  // Shift amount for the current step and whether the top bits it would
  // discard are all zero.
  logic [4:0]  step_amt;
  logic        top_zero;

  // Decode step index k into shift amount 16>>k and test the top window.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    step_amt = 5'd0;
    top_zero = 1'b0;
    case (k_q)
      3'd0: begin step_amt = 5'd16; top_zero = (y_q[31:16] == 16'd0); end
      3'd1: begin step_amt = 5'd8;  top_zero = (y_q[31:24] == 8'd0);  end
      3'd2: begin step_amt = 5'd4;  top_zero = (y_q[31:28] == 4'd0);  end
      3'd3: begin step_amt = 5'd2;  top_zero = (y_q[31:30] == 2'd0);  end
      3'd4: begin step_amt = 5'd1;  top_zero = (y_q[31] == 1'b0);     end
      default: begin step_amt = 5'd0; top_zero = 1'b0; end
    endcase
  end

  // Next-state and datapath update for the IDLE/STEP/DONE sequence.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    y_d      = y_q;
    sa_d     = sa_q;
    iszero_d = iszero_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          y_d      = X;
          sa_d     = 5'd0;
          k_d      = 3'd0;
          iszero_d = 1'b0;
          state_d  = S_STEP;
        end
      end

      S_STEP: begin
        // Sum of all step amounts is 31, so the 5-bit count never wraps.
        if (top_zero) begin
          y_d  = y_q << step_amt;
          sa_d = sa_q + step_amt;
        end
        if (k_q == LAST_STEP) begin
          k_d      = 3'd0;
          iszero_d = (y_d == 32'd0);
          state_d  = S_DONE;
        end else begin
          k_d = k_q + 3'd1;
        end
      end

      S_DONE: begin
        // Start arriving here is deliberately dropped, not queued.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        k_d     = 3'd0;
      end
    endcase
  end

  // State and datapath registers; synchronous reset wins over everything.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (Reset) begin
      state_q  <= S_IDLE;
      k_q      <= 3'd0;
      y_q      <= 32'd0;
      sa_q     <= 5'd0;
      iszero_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      y_q      <= y_d;
      sa_q     <= sa_d;
      iszero_q <= iszero_d;
    end
  end

  assign Busy   = (state_q == S_STEP);
  assign Done   = (state_q == S_DONE);
  assign Y      = y_q;
  assign Sa     = sa_q;
  assign IsZero = iszero_q;

endmodule

// File: doc/norm_x32.md
NORM_X32 -- requirements
Module: norm_x32

Interface
REQ-001 The block SHALL run on one clock; reset is synchronous and active-high (Clk, Reset).
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous, active-high; clears all state on the next Clk edge.
REQ-004 Start  input  1  request pulse; sampled only in IDLE.
REQ-005 X  input  32  operand, captured on the Clk edge that accepts Start.
REQ-006 Busy  output  1  high while normalization steps are in progress.
REQ-007 Done  output  1  one-cycle result-valid pulse.
REQ-008 Y  output  32  normalized value: X shifted left until bit 31 = 1.
REQ-009 Sa  output  5  left-shift count (leading-zero count of X).
REQ-010 IsZero  output  1  high with the result when the captured X was 0.

Function
REQ-011 FSM states SHALL be IDLE, STEP and DONE; a 3-bit step index k (0..4) SHALL be valid in STEP.
REQ-012 IDLE with Start=1 at an edge -> capture X into Y, clear Sa to 0, set k=0, go to STEP.
REQ-013 IDLE with Start=0 -> remain in IDLE; Y, Sa and IsZero hold.
REQ-014 Each STEP edge SHALL use amount A = 16>>k (16, 8, 4, 2, 1).
REQ-015 In that step, if Y[31:32-A] is all zero: Y <= Y<<A (zero fill) and Sa <= Sa+A; otherwise Y and Sa hold.
REQ-016 After k=4 the FSM SHALL go to DONE; otherwise k increments.
REQ-017 Latency SHALL be fixed: Start accepted at edge t -> steps at edges t+1..t+5 -> Done=1 in the cycle after edge t+5.
REQ-018 Latency SHALL not depend on the data.
REQ-019 DONE SHALL last exactly one cycle, then go to IDLE; Done=1 only in DONE.
REQ-020 Busy SHALL be 1 exactly in STEP, covering 5 cycles per operation.
REQ-021 IsZero SHALL be set at the DONE transition when Y==0, and cleared on acceptance of a new Start.
REQ-022 For X=0: Sa = 31 (16+8+4+2+1), Y = 0, IsZero = 1.
REQ-023 Sa SHALL never exceed 31; the arithmetic is 5-bit with no wrap.
REQ-024 Start in STEP or DONE SHALL be ignored; it is neither queued nor allowed to corrupt the operation in flight.
REQ-025 Y, Sa and IsZero SHALL hold from DONE until the next accepted Start.
REQ-026 For any X != 0: Y[31] = 1, Y == X<<Sa, and Sa equals the leading-zero count of X.

Reset
REQ-027 Reset=1 at an edge -> state IDLE, k=0, Busy=0, Done=0, Y=0, Sa=0, IsZero=0.
REQ-028 Reset SHALL take priority over Start and over any step in progress.
REQ-029 Reset mid-operation SHALL abort the operation with no Done pulse.
REQ-030 Start coincident with Reset SHALL be ignored.
REQ-031 The first Start after Reset deasserts SHALL be accepted normally.

Verification
REQ-032 X=0x00000001, Start 1 cycle -> Busy 5 cycles, then Done=1 with Y=0x80000000, Sa=31, IsZero=0.
REQ-033 X=0x00000000 -> Done with Y=0x00000000, Sa=31, IsZero=1.
REQ-034 X=0x80000000 -> Done with Y=0x80000000, Sa=0, IsZero=0; latency is still 5 Busy cycles.
REQ-035 X=0x00012345 -> Y=0x91A28000, Sa=15; a second Start with X=0xFFFFFFFF pulsed during Busy is ignored (result unchanged, exactly one Done).
REQ-036 Reset asserted at the third Busy cycle -> next cycle all outputs 0 and IDLE, no Done; a following Start X=0x00400000 -> Sa=9, Y=0x80000000.
REQ-037 The bench SHALL compare 10k random X against a reference leading-zero-count/shift model, with back-to-back Starts issued the cycle after each Done.
